// File: rtl/btn_conditioner_pkg.sv
// btn_conditioner_pkg
//   Shared definitions for the pushbutton conditioner:
//   - per-channel auto-repeat FSM state encoding
//   - button bit positions inside the 3-bit button vectors
//   - helper for sizing counters so they never wrap
package btn_conditioner_pkg;

    localparam int NUM_BTNS = 3;

    // Bit positions in btn_raw / btn_level / btn_press / ...
    localparam int BTN_D = 0;
    localparam int BTN_S = 1;
    localparam int BTN_U = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if
//   Groups the button bus between the board-side pins and the game logic.
//   btn_raw     : unsynchronised pushbuttons (bit2 = U, bit1 = S, bit0 = D)
//   btn_level   : debounced state, 1 = held
//   btn_press   : one-cycle pulse on each debounced 0->1
//   btn_release : one-cycle pulse on each debounced 1->0
//   btn_repeat  : one-cycle auto-repeat pulses while held
//   master = side driving btn_raw, slave = the conditioner.
interface btn_conditioner_if
    import btn_conditioner_pkg::*;
();
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_release;
    logic [NUM_BTNS-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_repeat
    );
endinterface

// File: rtl/btn_channel.sv
// btn_channel
//   One button: two-flop synchroniser, debounce counter, press/release edge
//   pulses and the IDLE/HOLD/REPEAT auto-repeat FSM.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active low
//   raw   : unsynchronised button input
//   level : debounced level, 1 = held
//   press : one-cycle pulse in the first cycle level reads 1
//   rel   : one-cycle pulse in the first cycle level reads 0
//   rpt   : auto-repeat pulse while held
import btn_conditioner_pkg::*;

module btn_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int HOLD_W = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE) - 1);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

    logic              sync1, sync;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    btn_state_t        state;
    logic              db_done;

    // Level flips on this edge: input has disagreed for DEBOUNCE_CYCLES in a row.
    assign db_done = (sync != level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync  <= sync1;
        end
    end

    // Any agreeing cycle restarts the count, so short glitches never land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            press <= db_done && !level;
            rel   <= db_done &&  level;
            if (sync == level) begin
                db_cnt <= '0;
            end else if (db_done) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // A release wins over everything, which also swallows a repeat that
    // would have fired on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            rpt      <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (db_done && level) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        hold_cnt <= '0;
                        if (db_done) state <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_cnt == DELAY_LAST) begin
                            state    <= ST_REPEAT;
                            hold_cnt <= '0;
                            rpt      <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (hold_cnt == RATE_LAST) begin
                            hold_cnt <= '0;
                            rpt      <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner
//   Three independent pushbutton channels (D, S, U) feeding game logic
//   directly on the system clock; no derived clocks.
//   clk : system clock, rising edge
//   rst : asynchronous reset, active low
//   bus : slave side of the button bus (raw in; level/press/release/repeat out)
import btn_conditioner_pkg::*;

module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic                     clk,
    input  logic                     rst,
    btn_conditioner_if.slave         bus
);
    logic [NUM_BTNS-1:0] level_v, press_v, rel_v, rpt_v;

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch [NUM_BTNS-1:0] (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_raw),
        .level (level_v),
        .press (press_v),
        .rel   (rel_v),
        .rpt   (rpt_v)
    );

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = rel_v;
    assign bus.btn_repeat  = rpt_v;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner
//   Directed scenarios plus randomized button activity, checked every cycle
//   against a window-based reference model of debounce and repeat timing.
import btn_conditioner_pkg::*;

module tb_btn_conditioner;
    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    btn_conditioner_if bif ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [2:0] samp [0:8191];   // raw value each edge saw (0 while in reset)
    int         e = 0;           // edge index
    logic [2:0] raw_v = 3'b000;
    logic [2:0] lvl_m, exp_press, exp_rel, exp_rep;
    int         pe [3];          // edge of most recent press per bit

    task automatic model_reset();
        lvl_m = '0; exp_press = '0; exp_rel = '0; exp_rep = '0;
    endtask

    // Level toggles at edge n when the raw samples from edges n-1-DC .. n-2
    // all disagree with the current level. Repeat fires RD edges after the
    // press and every RR edges thereafter while still held.
    task automatic model_edge();
        logic tog;
        int   d;
        if (!rst) begin
            samp[e] = 3'b000;
            model_reset();
            return;
        end
        samp[e] = raw_v;
        for (int b = 0; b < 3; b++) begin
            tog = 1'b0;
            if (e - 1 - DC >= 0) begin
                tog = 1'b1;
                for (int j = e - 1 - DC; j <= e - 2; j++)
                    if (samp[j][b] == lvl_m[b]) tog = 1'b0;
            end
            exp_press[b] = tog && !lvl_m[b];
            exp_rel[b]   = tog &&  lvl_m[b];
            lvl_m[b]     = lvl_m[b] ^ tog;
            if (exp_press[b]) pe[b] = e;
            d = e - pe[b];
            exp_rep[b] = lvl_m[b] && !tog && (d >= RD) && ((d - RD) % RR == 0);
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, got, exp);
        end
    endtask

    task automatic check_all();
        chk("outputs", {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat},
            {lvl_m, exp_press, exp_rel, exp_rep});
        chk("rep_excl", {9'b0, bif.btn_repeat & (bif.btn_press | bif.btn_release)}, 12'h000);
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_raw(input logic [2:0] v);
        raw_v = v;
        bif.btn_raw = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    int  cd [3];
    bit  found;
    logic [2:0] r;

    initial begin
        for (int i = 0; i < 8192; i++) samp[i] = 3'b000;
        for (int b = 0; b < 3; b++) pe[b] = 0;
        model_reset();
        bif.btn_raw = 3'b000;

        // Reset state, including a raw input that is already high
        set_raw(3'b111);
        #1;
        chk("reset_async", {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat}, 12'h000);
        for (int i = 0; i < 3; i++) tick();
        set_raw(3'b000);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Bit0 clean step: level and press land DC+1 edges after the sampling edge
        set_raw(3'b001);
        for (int i = 1; i <= DC + 3; i++) begin
            tick();
            if (i == DC + 1) chk("d_level_early", {9'b0, bif.btn_level}, 12'h000);
            if (i == DC + 2) chk("d_press", {6'b0, bif.btn_level, bif.btn_press}, {6'b0, 3'b001, 3'b001});
            if (i == DC + 3) chk("d_press_once", {9'b0, bif.btn_press}, 12'h000);
        end

        // Bit1 glitch of 3 cycles is rejected
        set_raw(3'b011);
        for (int i = 0; i < 3; i++) tick();
        set_raw(3'b001);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s_glitch", {10'b0, bif.btn_level[1], bif.btn_press[1]}, 12'h000);
        end

        // Bit0 release: one pulse DC+1 edges later, repeats stop
        set_raw(3'b000);
        for (int i = 1; i <= DC + 2; i++) tick();
        chk("d_release", {6'b0, bif.btn_release, bif.btn_repeat}, {6'b0, 3'b001, 3'b000});
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("d_no_rep", {10'b0, bif.btn_repeat[0], bif.btn_release[0]}, 12'h000);
        end

        // Bit2 held 30 cycles after press: repeat at +RD, +RD+RR, ...
        set_raw(3'b100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bif.btn_press[2]) found = 1'b1;
        end
        chk("u_press_seen", {11'b0, found}, 12'h001);
        for (int j = 1; j <= 30; j++) begin
            tick();
            chk("u_repeat", {10'b0, bif.btn_repeat[2], bif.btn_press[2]},
                {10'b0, (j >= RD) && ((j - RD) % RR == 0), 1'b0});
        end
        set_raw(3'b000);
        for (int i = 0; i < 12; i++) tick();

        // Bits 0 and 2 stepped together press on the same edge
        set_raw(3'b101);
        for (int i = 1; i <= DC + 2; i++) tick();
        chk("du_press", {9'b0, bif.btn_press}, 12'h005);
        set_raw(3'b000);
        for (int i = 0; i < 12; i++) tick();

        // Bit1 in REPEAT, reset mid-press, still held after reset
        set_raw(3'b010);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bif.btn_repeat[1]) found = 1'b1;
        end
        chk("s_repeat_seen", {11'b0, found}, 12'h001);
        tick();
        rst = 1'b0;
        #1;
        model_reset();
        chk("s_reset_async", {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat}, 12'h000);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        for (int i = 1; i <= DC + 3; i++) begin
            tick();
            chk("s_no_release", {11'b0, bif.btn_release[1]}, 12'h000);
            if (i == DC + 1) chk("s_press_early", {11'b0, bif.btn_press[1]}, 12'h000);
            if (i == DC + 2) chk("s_press_after_rst", {11'b0, bif.btn_press[1]}, 12'h001);
        end
        set_raw(3'b000);
        for (int i = 0; i < 12; i++) tick();

        // Randomized activity: mix of glitches and long holds, rare resets
        for (int b = 0; b < 3; b++) cd[b] = 1 + b;
        r = 3'b000;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < 3; b++) begin
                cd[b]--;
                if (cd[b] <= 0) begin
                    r[b] = ~r[b];
                    cd[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(5, 40));
                end
            end
            set_raw(r);
            rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-cycles required before a debounced level changes (min 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, held-cycles from press pulse to first repeat pulse (min 2).
REQ-003 SHALL have parameter REPEAT_RATE, default 10000000, cycles between subsequent repeat pulses (min 2).
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 SHALL have port btn_raw  input  3  unsynchronised pushbuttons; bit2 = btnU, bit1 = btnS, bit0 = btnD.
REQ-007 SHALL have port btn_level  output  3  debounced button state, 1 = held.
REQ-008 SHALL have port btn_press  output  3  one-cycle pulse per debounced 0->1 transition.
REQ-009 SHALL have port btn_release  output  3  one-cycle pulse per debounced 1->0 transition.
REQ-010 SHALL have port btn_repeat  output  3  one-cycle auto-repeat pulses while held.

Function
REQ-011 Each bit SHALL be processed by an independent channel; there is no cross-channel interaction, so simultaneous events on several bits are all reported in the same cycle.
REQ-012 Each channel SHALL pass btn_raw through a two-flop synchroniser; only the second-flop output (sync) feeds later logic.
REQ-013 The debounce counter SHALL increment each cycle that sync != btn_level and SHALL clear to 0 on any cycle that sync == btn_level (glitch rejection).
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and sync != btn_level, the next edge SHALL toggle btn_level and clear the counter.
REQ-015 A clean raw step sampled at edge k SHALL change btn_level at edge k+1+DEBOUNCE_CYCLES.
REQ-016 btn_press / btn_release SHALL be registered, high exactly in the first cycle btn_level shows the new value, low otherwise.
REQ-017 Each channel SHALL run FSM IDLE, HOLD, REPEAT: IDLE->HOLD on press; HOLD->REPEAT when hold counter reaches REPEAT_DELAY-1; REPEAT stays while held; HOLD/REPEAT->IDLE on release.
REQ-018 The hold counter SHALL clear on entry to HOLD and on every repeat pulse, and SHALL increment each cycle in HOLD/REPEAT.
REQ-019 btn_repeat SHALL pulse REPEAT_DELAY cycles after btn_press, then every REPEAT_RATE cycles while held.
REQ-020 btn_repeat SHALL never coincide with btn_press or btn_release on the same bit; a release in the cycle a repeat would fire suppresses that repeat.
REQ-021 Counters SHALL be sized to hold their maximum value without wrap; they SHALL never exceed DEBOUNCE_CYCLES-1, REPEAT_DELAY-1 or REPEAT_RATE-1 respectively.

Reset
REQ-022 While rst = 0, synchroniser flops, counters, btn_level, btn_press, btn_release, btn_repeat SHALL be 0 and every FSM in IDLE, independent of clk.
REQ-023 Reset assertion mid-press SHALL abort without emitting btn_release; a button still held after reset deassertion SHALL produce btn_press per REQ-015.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, button index constants (BTN_D=0, BTN_S=1, BTN_U=2) and counter-width helper constants.
REQ-025 The block SHALL instantiate one sub-module btn_channel three times (synchroniser, debounce, edge, repeat FSM for one bit).
REQ-026 Outputs feed the game logic stage directly; the block SHALL contain no clock-divider logic and use no derived clocks.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-027 Raw bit0 0->1 at edge 10, held -> btn_level[0] rises and btn_press[0] pulses for one cycle at edge 15; other bits stay 0.
REQ-028 Raw bit1 pulses high for 3 cycles -> btn_level[1], btn_press[1] stay 0 throughout.
REQ-029 Bit2 held 30 cycles after press -> btn_repeat[2] pulses at press+10, +13, +16, ... and never with btn_press[2].
REQ-030 Bits 0 and 2 stepped on the same edge -> btn_press[0] and btn_press[2] pulse in the same cycle.
REQ-031 rst driven 0 while bit1 is in REPEAT, raw still high -> all outputs 0 immediately; after rst=1, btn_press[1] pulses 5 cycles later, no btn_release[1].
REQ-032 Release bit0 after level high -> btn_release[0] pulses once, 5 cycles after raw falls; btn_repeat[0] stops.
